unidad_deteccion_riesgos: RTL and testbench

Pipeline hazard-detection and stall controller for the 5-stage MIPS core; it resolves the hazards that the forwarding logic cannot bypass. Sits beside the ID and EX stages, drives the pipeline-register write enables and flush lines, and sequences multi-cycle mul/div occupancy of EX and data-memory wait states. A taken branch flushes the wrong-path instructions.

---
 rtl/unidad_deteccion_riesgos_pkg.sv | 14 +
 rtl/unidad_deteccion_riesgos_contador_muldiv.sv | 39 +++
 rtl/unidad_deteccion_riesgos.sv | 160 ++++++++++++++++
 tb/tb_unidad_deteccion_riesgos.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/unidad_deteccion_riesgos_pkg.sv
// rtl/unidad_deteccion_riesgos_pkg.sv - shared types and widths for the hazard unit
// Contents: FSM state encoding, register-index width, mul/div countdown width.
package unidad_deteccion_riesgos_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MULDIV   = 2'd1,
    MEM_WAIT = 2'd2
  } estado_t;

endpackage

// File: rtl/unidad_deteccion_riesgos_contador_muldiv.sv
// rtl/unidad_deteccion_riesgos_contador_muldiv.sv - loadable down-counter for mul/div occupancy
// Ports: clk, reset (async, active-high), load/load_value (load has priority),
//        enable (decrement, stops at zero), cnt (current value), is_one (cnt == 1).
module contador_muldiv
  import unidad_deteccion_riesgos_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/unidad_deteccion_riesgos.sv
// rtl/unidad_deteccion_riesgos.sv - MIPS hazard detection and stall controller
// Inputs : clk, reset (async, active-high), ID source regs, EX dest reg / load / mul-div,
//          EX branch-taken, MEM request/ready.
// Outputs: pc/if_id/id_ex/ex_mem write enables, if_id/id_ex/ex_mem flushes, muldiv_busy,
//          and stall_count when HAZARD_STALL_COUNT_EN is defined.
module unidad_deteccion_riesgos
  import unidad_deteccion_riesgos_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_memRead,
  input  logic             id_ex_muldiv,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             muldiv_busy
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  estado_t          state_q;
  estado_t          state_d;
  estado_t          eval_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             cnt_load;
  logic             cnt_en;
  logic             mem_wait;
  logic             load_use;
  logic             hold;
  logic             stall;
  logic             lu_stall;
  logic             br_flush;

  assign mem_wait = mem_req && !mem_ready;
  assign load_use = id_ex_memRead && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  contador_muldiv u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_W'(MULDIV_LATENCY - 1)),
    .enable     (cnt_en),
    .cnt        (cnt),
    .is_one     (cnt_is_one)
  );

  always_comb begin
    state_d    = state_q;
    eval_state = state_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    hold       = 1'b0;
    stall      = 1'b0;
    lu_stall   = 1'b0;
    br_flush   = 1'b0;
    // The cycle that ends a memory wait resumes whatever was interrupted:
    // a pending mul/div countdown, otherwise normal issue.
    if (state_q == MEM_WAIT) begin
      eval_state = (cnt != '0) ? MULDIV : RUN;
    end
    if (mem_wait) begin
      hold    = 1'b1;
      state_d = MEM_WAIT;
    end else begin
      case (eval_state)
        MULDIV: begin
          cnt_en = 1'b1;
          if (cnt_is_one || (cnt == '0)) begin
            state_d = RUN;
          end else begin
            stall   = 1'b1;
            state_d = MULDIV;
          end
        end
        default: begin
          state_d = RUN;
          if (id_ex_muldiv && (MULDIV_LATENCY >= 2)) begin
            stall    = 1'b1;
            cnt_load = 1'b1;
            state_d  = MULDIV;
          end else if (ex_branch_taken) begin
            // Load-use on the wrong path is irrelevant once the branch flushes it.
            br_flush = 1'b1;
          end else if (load_use) begin
            lu_stall = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced to the free-running values while reset is held.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_busy  = 1'b0;
    if (!reset) begin
      pc_write     = !(hold || stall || lu_stall);
      if_id_write  = !(hold || stall || lu_stall);
      id_ex_write  = !(hold || stall);
      ex_mem_write = !hold;
      if_id_flush  = br_flush;
      id_ex_flush  = br_flush || lu_stall;
      ex_mem_flush = stall;
      muldiv_busy  = (state_q == MULDIV);
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_unidad_deteccion_riesgos.sv
// tb/tb_unidad_deteccion_riesgos.sv - directed self-checking bench for unidad_deteccion_riesgos
module tb_unidad_deteccion_riesgos;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       id_ex_memRead, id_ex_muldiv, ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {pc, if_id, id_ex, ex_mem writes, if_id, id_ex, ex_mem flushes, busy}
  localparam logic [7:0] O_NORM   = 8'hF0;
  localparam logic [7:0] O_STALL  = 8'h12;
  localparam logic [7:0] O_STALLB = 8'h13;
  localparam logic [7:0] O_ADVB   = 8'hF1;
  localparam logic [7:0] O_LU     = 8'h34;
  localparam logic [7:0] O_BR     = 8'hFC;
  localparam logic [7:0] O_HOLDB  = 8'h01;
  localparam logic [7:0] O_HOLD   = 8'h00;

  unidad_deteccion_riesgos #(.MULDIV_LATENCY(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_ex_rt        (id_ex_rt),
    .id_ex_memRead   (id_ex_memRead),
    .id_ex_muldiv    (id_ex_muldiv),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .muldiv_busy     (muldiv_busy)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    if_id_rs = 5'd0; if_id_rt = 5'd0; id_ex_rt = 5'd0;
    id_ex_memRead = 1'b0; id_ex_muldiv = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic co(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, outs()}, {24'd0, exp});
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    co("reset_outs", O_NORM);
    tick(); reset = 1'b0;
    co("idle", O_NORM);

    // Load-use via rs, then via rt, then rt==0 and a non-matching register
    tick(); id_ex_memRead = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    co("lu_rs", O_LU);
    tick(); clr_in();
    co("lu_one_cycle", O_NORM);
    tick(); id_ex_memRead = 1'b1; id_ex_rt = 5'd9; if_id_rt = 5'd9;
    co("lu_rt", O_LU);
    tick(); clr_in(); id_ex_memRead = 1'b1; id_ex_rt = 5'd0;
    co("lu_r0", O_NORM);
    tick(); id_ex_rt = 5'd3; if_id_rs = 5'd4; if_id_rt = 5'd5;
    co("lu_nomatch", O_NORM);

    // Mul/div, latency 4: id_ex_muldiv held high to show it is ignored in MULDIV
    tick(); clr_in(); id_ex_muldiv = 1'b1;
    co("md_t0", O_STALL);
    tick(); co("md_t1", O_STALLB);
    tick(); co("md_t2", O_STALLB);
    tick(); co("md_t3_adv", O_ADVB);
    tick(); id_ex_muldiv = 1'b0;
    co("md_t4_run", O_NORM);

    // Mul/div with a 3-cycle memory wait starting at t+1
    tick(); id_ex_muldiv = 1'b1;
    co("mw_t0", O_STALL);
    tick(); mem_req = 1'b1; mem_ready = 1'b0;
    co("mw_t1_hold", O_HOLDB);
    tick(); co("mw_t2_hold", O_HOLD);
    tick(); co("mw_t3_hold", O_HOLD);
    tick(); mem_ready = 1'b1;
    co("mw_t4_resume", O_STALL);
    tick(); mem_req = 1'b0; mem_ready = 1'b0;
    co("mw_t5", O_STALLB);
    tick(); co("mw_t6_adv", O_ADVB);
    tick(); id_ex_muldiv = 1'b0;
    co("mw_t7_run", O_NORM);

    // Branch overrides load-use; memory wait overrides branch
    tick(); ex_branch_taken = 1'b1; id_ex_memRead = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    co("br_lu", O_BR);
    tick(); mem_req = 1'b1;
    co("mem_over_br", O_HOLD);
    tick(); clr_in();
    co("after_mem", O_NORM);

    // Reset while in MULDIV with cnt == 2
    tick(); id_ex_muldiv = 1'b1;
    co("rs_t0", O_STALL);
    tick(); co("rs_t1", O_STALLB);
    tick(); chk("rs_cnt2", {28'd0, dut.u_cnt.cnt_q}, 32'd2);
    reset = 1'b1;
    co("rs_immediate", O_NORM);
    chk("rs_cnt_clr", {28'd0, dut.u_cnt.cnt_q}, 32'd0);
    tick(); reset = 1'b0; id_ex_muldiv = 1'b0;
    co("rs_release", O_NORM);
    chk("rs_state_run", {30'd0, dut.state_q}, 32'd0);

`ifdef HAZARD_STALL_COUNT_EN
    // Two load-use stalls plus one latency-4 mul/div (3 stall cycles)
    tick(); id_ex_memRead = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    tick(); clr_in();
    tick(); id_ex_memRead = 1'b1; id_ex_rt = 5'd8; if_id_rt = 5'd8;
    tick(); clr_in(); id_ex_muldiv = 1'b1;
    tick(); tick(); tick(); id_ex_muldiv = 1'b0;
    tick(); #1;
    chk("stall_count", stall_count, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
